div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider for the execute side of the pipeline, the inverse companion to the multiplier stages. It accepts one dividend/divisor pair plus destination register, runs a radix-2 restoring division over 32 cycles, and returns a 64-bit {remainder, quotient} result tagged with the destination register. While busy it stalls issue, and it produces a one-cycle result pulse for writeback.

## Interface
Parameters:
- none; widths are fixed by package constants.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- d_in_oper  in  1  issue strobe; sampled only while idle.
- d_in_rega  in  32  dividend.
- d_in_regb  in  32  divisor.
- d_in_regdest  in  5  destination register tag.
- d_in_signed  in  1  1 = signed (two's complement), 0 = unsigned.
- d_busy  out  1  high while an operation is in flight; issue must hold.
- d_out_oper  out  1  result valid, single-cycle pulse.
- d_out_divres  out  64  {remainder[31:0], quotient[31:0]}.
- d_out_regdest  out  5  tag of the completed operation.
- d_out_divzero  out  1  divisor was zero.

## Operation
- States are IDLE, RUN and FIX. d_busy = (state != IDLE).
- IDLE:
  - If d_in_oper=1, capture the operands, tag and signed flag.
  - Convert the operands to magnitudes when signed, record the quotient and remainder signs, and clear the partial remainder and the iteration counter. Go to RUN.
  - If d_in_oper=0, hold state.
- RUN: one restoring step per cycle.
  - Shift the next dividend bit into the partial remainder.
  - Trial-subtract the divisor magnitude. Keep the difference if it is non-negative, and shift the quotient bit in (1 if kept, else 0).
  - After 32 steps go to FIX.
- FIX:
  - Negate the quotient when the operand signs differ (signed only).
  - Negate the remainder when the dividend is negative (signed only).
  - Register the outputs, pulse d_out_oper, and return to IDLE.
- Divisor zero:
  - Runs the full latency.
  - Result is quotient 0xFFFF_FFFF and remainder equal to the raw dividend, with no sign fix.
  - d_out_divzero=1.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0. This is the natural wrap; no flag is raised.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- d_in_oper asserted while d_busy=1 is ignored, with no queueing.
- Outputs other than d_out_oper hold their last result until the next completion.

## Timing
- Reset value of every output is 0, and state is IDLE. This holds on reset at any point, including mid-RUN; the in-flight operation is discarded.
- Accept happens at edge E0, where IDLE samples d_in_oper=1.
- RUN steps occur at E1 through E32. FIX registers the result at E33.
- d_out_oper is high for exactly the cycle following E33. Latency is 33 clocks, fixed.
- d_busy is high from after E0 until after E33. During the d_out_oper cycle d_busy=0, so a new issue may be accepted then (back-to-back throughput is one op per 34 cycles).
- d_out_oper is cleared at the next edge after its pulse.

## Configuration
- DIV_SIGNED_EN:
  - Defined: d_in_signed is honoured, and the sign capture and FIX negation logic are present.
  - Undefined: d_in_signed is ignored and all operations are unsigned. FIX only registers the result, but latency stays 33.

## Structure
- Package div_pkg holds:
  - state enum (IDLE, RUN, FIX);
  - DIV_WIDTH=32 and DIV_ITER=32;
  - DIV_CNT_W=6;
  - DIVZERO_QUOT=32'hFFFF_FFFF.
- Sub-module div_step: purely combinational single restoring step. It takes partial remainder, next dividend bit and divisor magnitude, and returns the new partial remainder and quotient bit. It is instantiated once in div_unit.

## Test plan
- Unsigned 100 / 7, tag 3 → after 33 clocks, d_out_oper pulse, divres={32'd2, 32'd14}, regdest=3, divzero=0.
- Signed -7 / 2 → quotient 0xFFFF_FFFD (-3), remainder 0xFFFF_FFFF (-1). With DIV_SIGNED_EN undefined, the same operands give quotient 0x7FFF_FFFC and remainder 1.
- 5 / 0 → quotient 0xFFFF_FFFF, remainder 5, divzero=1, same 33-clock latency.
- Signed 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0.
- Issue 100/7; at cycle 5 issue 9/3 while busy → only the 100/7 result appears. Issuing 9/3 in the d_out_oper cycle yields {0, 3} 33 clocks later.
- Reset asserted at cycle 10 of RUN → all outputs 0, d_busy=0 immediately. After release, 50/5 completes with {0, 10}.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITER  = 32;
    localparam int unsigned DIV_CNT_W = 6;

    localparam logic [DIV_WIDTH-1:0] DIVZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_in,
    input  logic                 dvd_bit,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_out,
    output logic                 quo_bit
);

    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        quo_bit = (shifted >= {1'b0, divisor});
        // When the subtraction is kept the true difference fits in DIV_WIDTH bits.
        diff    = shifted[DIV_WIDTH-1:0] - divisor;
        rem_out = quo_bit ? diff : shifted[DIV_WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider: 32 restoring steps plus one fix cycle, 33-clock latency.
// Signed operation is built in only when DIV_SIGNED_EN is defined.
module div_unit
    import div_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   d_in_oper,
    input  logic [DIV_WIDTH-1:0]   d_in_rega,
    input  logic [DIV_WIDTH-1:0]   d_in_regb,
    input  logic [4:0]             d_in_regdest,
    input  logic                   d_in_signed,
    output logic                   d_busy,
    output logic                   d_out_oper,
    output logic [2*DIV_WIDTH-1:0] d_out_divres,
    output logic [4:0]             d_out_regdest,
    output logic                   d_out_divzero
);

    div_state_e state_q, state_d;

    logic [DIV_WIDTH-1:0]   dvd_q, dsr_q, rem_q, quo_q, raw_q;
    logic [DIV_CNT_W-1:0]   cnt_q;
    logic [4:0]             tag_q;
    logic                   zero_q;
    logic                   oper_q;
    logic [2*DIV_WIDTH-1:0] divres_q;
    logic [4:0]             regdest_q;
    logic                   divzero_q;

    logic [DIV_WIDTH-1:0] dvd_mag, dsr_mag, step_rem, quo_fix, rem_fix;
    logic                 step_bit;
    logic                 last_step;

    assign last_step = (cnt_q == DIV_CNT_W'(DIV_ITER - 1));

    div_step u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[DIV_WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .quo_bit (step_bit)
    );

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_rem_q;
    logic cap_neg_quo, cap_neg_rem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state_q == StIdle && d_in_oper) begin
            neg_quo_q <= cap_neg_quo;
            neg_rem_q <= cap_neg_rem;
        end
    end
`else
    logic unused_signed;
    assign unused_signed = d_in_signed;
`endif

    // Operand magnitudes at issue
    always_comb begin
        dvd_mag = d_in_rega;
        dsr_mag = d_in_regb;
`ifdef DIV_SIGNED_EN
        cap_neg_rem = d_in_signed & d_in_rega[DIV_WIDTH-1];
        cap_neg_quo = d_in_signed & (d_in_rega[DIV_WIDTH-1] ^ d_in_regb[DIV_WIDTH-1]);
        if (cap_neg_rem) dvd_mag = -d_in_rega;
        if (d_in_signed && d_in_regb[DIV_WIDTH-1]) dsr_mag = -d_in_regb;
`endif
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (d_in_oper) state_d = StRun;
            StRun:   if (last_step) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs and sign/zero fix-up of the finished result
    always_comb begin
        d_busy  = (state_q != StIdle);
        quo_fix = quo_q;
        rem_fix = rem_q;
`ifdef DIV_SIGNED_EN
        if (neg_quo_q) quo_fix = -quo_q;
        if (neg_rem_q) rem_fix = -rem_q;
`endif
        if (zero_q) begin
            quo_fix = DIVZERO_QUOT;
            rem_fix = raw_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            raw_q     <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
            zero_q    <= 1'b0;
            oper_q    <= 1'b0;
            divres_q  <= '0;
            regdest_q <= '0;
            divzero_q <= 1'b0;
        end else begin
            oper_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (d_in_oper) begin
                        dvd_q  <= dvd_mag;
                        dsr_q  <= dsr_mag;
                        raw_q  <= d_in_rega;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        cnt_q  <= '0;
                        tag_q  <= d_in_regdest;
                        zero_q <= (d_in_regb == '0);
                    end
                end
                StRun: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[DIV_WIDTH-2:0], step_bit};
                    dvd_q <= {dvd_q[DIV_WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + DIV_CNT_W'(1);
                end
                StFix: begin
                    oper_q    <= 1'b1;
                    divres_q  <= {rem_fix, quo_fix};
                    regdest_q <= tag_q;
                    divzero_q <= zero_q;
                end
                default: ;
            endcase
        end
    end

    assign d_out_oper    = oper_q;
    assign d_out_divres  = divres_q;
    assign d_out_regdest = regdest_q;
    assign d_out_divzero = divzero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit; expectations follow the DIV_SIGNED_EN setting.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        d_in_oper = 1'b0;
    logic [31:0] d_in_rega = '0;
    logic [31:0] d_in_regb = '0;
    logic [4:0]  d_in_regdest = '0;
    logic        d_in_signed = 1'b0;
    logic        d_busy;
    logic        d_out_oper;
    logic [63:0] d_out_divres;
    logic [4:0]  d_out_regdest;
    logic        d_out_divzero;

    div_unit dut (
        .clock         (clock),
        .reset         (reset),
        .d_in_oper     (d_in_oper),
        .d_in_rega     (d_in_rega),
        .d_in_regb     (d_in_regb),
        .d_in_regdest  (d_in_regdest),
        .d_in_signed   (d_in_signed),
        .d_busy        (d_busy),
        .d_out_oper    (d_out_oper),
        .d_out_divres  (d_out_divres),
        .d_out_regdest (d_out_regdest),
        .d_out_divzero (d_out_divzero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

`ifdef DIV_SIGNED_EN
    localparam logic [63:0] EXP_M7_2 = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    localparam logic [63:0] EXP_OVF  = {32'h0000_0000, 32'h8000_0000};
`else
    localparam logic [63:0] EXP_M7_2 = {32'h0000_0001, 32'h7FFF_FFFC};
    localparam logic [63:0] EXP_OVF  = {32'h8000_0000, 32'h0000_0000};
`endif

    always @(posedge clock) cycle++;

    // Scoreboard: every result pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1 && d_out_oper === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result cycle=%0d divres=%h", cycle, d_out_divres);
            end else begin
                e = sb.pop_front();
                checks++;
                if (d_out_divres !== e.res) begin
                    errors++;
                    $display("FAIL divres got=%h exp=%h", d_out_divres, e.res);
                end
                checks++;
                if (d_out_regdest !== e.tag) begin
                    errors++;
                    $display("FAIL regdest got=%0d exp=%0d", d_out_regdest, e.tag);
                end
                checks++;
                if (d_out_divzero !== e.dz) begin
                    errors++;
                    $display("FAIL divzero got=%b exp=%b", d_out_divzero, e.dz);
                end
                checks++;
                if (cycle != e.due) begin
                    errors++;
                    $display("FAIL latency got_cycle=%0d exp_cycle=%0d", cycle, e.due);
                end
            end
        end
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
`ifdef DIV_SIGNED_EN
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end
`else
        if (sgn) r = a % b;
`endif
        return {r, q};
    endfunction

    // Drives an issue at the current negedge and releases it one cycle later.
    task automatic issue_now(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                             input logic sgn, input logic [63:0] res, input logic dz,
                             input bit push);
        exp_t e;
        d_in_oper    = 1'b1;
        d_in_rega    = a;
        d_in_regb    = b;
        d_in_regdest = tag;
        d_in_signed  = sgn;
        if (push) begin
            e.res = res;
            e.tag = tag;
            e.dz  = dz;
            e.due = cycle + 34;
            sb.push_back(e);
        end
        @(negedge clock);
        d_in_oper = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                         input logic sgn, input logic [63:0] res, input logic dz,
                         input bit push);
        @(negedge clock);
        issue_now(a, b, tag, sgn, res, dz, push);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wait_idle timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({d_busy, d_out_oper, d_out_divres, d_out_regdest, d_out_divzero} !== '0) begin
            errors++;
            $display("FAIL %s busy=%b oper=%b divres=%h regdest=%0d divzero=%b exp=all0",
                     name, d_busy, d_out_oper, d_out_divres, d_out_regdest, d_out_divzero);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_zero_outputs("reset_values");
        reset = 1'b1;
        @(negedge clock);
        check_zero_outputs("after_release");
    endtask

    task automatic test_unsigned();
        issue(32'd100, 32'd7, 5'd3, 1'b0, {32'd2, 32'd14}, 1'b0, 1'b1);
        checks++;
        if (d_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_run got=%b exp=1", d_busy);
        end
        wait_idle();
        repeat (3) @(negedge clock);
        checks++;
        if (d_out_divres !== {32'd2, 32'd14} || d_out_regdest !== 5'd3 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL result_hold divres=%h regdest=%0d busy=%b exp=%h 3 0",
                     d_out_divres, d_out_regdest, d_busy, {32'd2, 32'd14});
        end
    endtask

    task automatic test_signed();
        issue(32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1, EXP_M7_2, 1'b0, 1'b1);
        wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, EXP_OVF, 1'b0, 1'b1);
        wait_idle();
    endtask

    task automatic test_divzero();
        issue(32'd5, 32'd0, 5'd9, 1'b0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 1'b1);
        wait_idle();
        issue(32'hFFFF_FFFB, 32'd0, 5'd10, 1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1, 1'b1);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        issue(32'd100, 32'd7, 5'd3, 1'b0, {32'd2, 32'd14}, 1'b0, 1'b1);
        repeat (4) @(negedge clock);
        checks++;
        if (d_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_ignored_issue got=%b exp=1", d_busy);
        end
        issue_now(32'd9, 32'd3, 5'd4, 1'b0, {32'd0, 32'd3}, 1'b0, 1'b0);
        while (d_out_oper !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (d_out_oper !== 1'b1 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_cycle oper=%b busy=%b exp=1 0", d_out_oper, d_busy);
        end
        issue_now(32'd9, 32'd3, 5'd4, 1'b0, {32'd0, 32'd3}, 1'b0, 1'b1);
        wait_idle();
    endtask

    task automatic test_reset_midrun();
        issue(32'd100, 32'd7, 5'd3, 1'b0, 64'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_zero_outputs("midrun_reset");
        @(negedge clock);
        reset = 1'b1;
        issue(32'd50, 32'd5, 5'd7, 1'b0, {32'd0, 32'd10}, 1'b0, 1'b1);
        wait_idle();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            if (i == 5) b = 32'hFFFF_FFFF;
            s = 1'($urandom_range(0, 1));
            issue(a, b, 5'(i + 16), s, model(a, b, s), (b == 32'd0), 1'b1);
            wait_idle();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d exp=finish", cycle);
        $fatal(1);
    end

endmodule
